// File: rtl/sinx_requester.sv
// Initiator-side sequencer for the sin(x) accelerator: admits one operand at a time,
// pulses start, waits for a done edge (or times out) and queues results in a small FIFO.
module sinx_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       x_valid_i,
  input  logic [15:0]                x_i,
  output logic                       x_ready_o,
  output logic                       acc_start_o,
  output logic [15:0]                acc_x_o,
  input  logic [15:0]                acc_result_i,
  input  logic                       acc_done_i,
  output logic                       y_valid_o,
  output logic [15:0]                y_o,
  input  logic                       y_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [15:0]     x_q;
  logic            done_q;
  logic [TW-1:0]   timer;
  logic            err_q;
  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            accept;
  logic            done_edge;
  logic            timeout_hit;
  logic            push;
  logic            pop;

  assign accept      = x_valid_i & x_ready_o;
  assign done_edge   = acc_done_i & ~done_q;
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign push        = (state == S_WAIT) & done_edge;
  assign pop         = y_ready_i & (count != '0);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = S_LAUNCH;
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT:   if (done_edge || timeout_hit) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      x_q    <= '0;
      done_q <= 1'b0;
      timer  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= acc_done_i;
      if (state == S_IDLE && accept)
        x_q <= x_i;
      if (state == S_LAUNCH)
        timer <= '0;
      else if (state == S_WAIT && !done_edge && !timeout_hit)
        timer <= timer + TW'(1);
      if (state == S_WAIT && !done_edge && timeout_hit)
        err_q <= 1'b1;
    end
  end

  // Storage needs no reset; flushing is done by clearing pointers and count.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= acc_result_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Admission only from IDLE with a free slot, so the pending result always fits.
  assign x_ready_o   = (state == S_IDLE) & (count < CW'(DEPTH)) & ~rst_i;
  assign acc_start_o = (state == S_LAUNCH);
  assign acc_x_o     = x_q;
  assign y_valid_o   = (count != '0);
  assign y_o         = y_valid_o ? mem[rd_ptr] : 16'h0000;
  assign count_o     = count;
  assign busy_o      = (state != S_IDLE);
  assign err_o       = err_q;

endmodule

// File: doc/sinx_requester.md
# sinx_requester

Initiator-side sequencer for the sin(x) accelerator: accepts a stream of x operands over a valid/ready interface and issues each one to the accelerator with a one-cycle start pulse. It then waits for the accelerator's done and pushes the result into a small output FIFO drained over valid/ready. It sits between the host datapath and the accelerator's start/x/result/done port group. It keeps at most one operation in flight and flags an accelerator that never answers.

## Interface
- DEPTH, 4, result FIFO entries; power of two, ≥2
- TIMEOUT, 64, max cycles in WAIT before abort; ≥2
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  asynchronous, active-high reset
- x_valid_i  in  1  operand valid
- x_i  in  16  operand
- x_ready_o  out  1  operand accepted when x_valid_i & x_ready_o at a clock edge
- acc_start_o  out  1  one-cycle start pulse to accelerator
- acc_x_o  out  16  operand to accelerator; held stable from LAUNCH until return to IDLE
- acc_result_i  in  16  accelerator result
- acc_done_i  in  1  accelerator done (pulse or level; rising edge is used)
- y_valid_o  out  1  FIFO non-empty
- y_o  out  16  FIFO head
- y_ready_i  in  1  consumer pops head when y_valid_o & y_ready_i
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky timeout flag

## Operation
- Reset state: IDLE, FIFO empty, err_o=0, x register=0, done edge register=0.
- All outputs are 0 during and after reset. Exception: x_ready_o is 1 after reset deasserts, and 0 while rst_i is high.
- x_ready_o = (state==IDLE) & (count_o < DEPTH) & ~rst_i.
- Admission reserves a FIFO slot, so a result write can never overflow, even while the consumer stalls.
- States:
  - IDLE: on accept, latch x_i into x register, go LAUNCH.
  - LAUNCH: acc_start_o=1 for exactly this cycle; clear timer; go WAIT.
  - WAIT: on done rising edge (acc_done_i & ~done_q), write acc_result_i to the FIFO and go IDLE. Otherwise, if timer==TIMEOUT-1, set err_o, write nothing, go IDLE. Otherwise increment timer.
- done_q registers acc_done_i every cycle in every state. A done level left high from a previous operation is not a new edge.
- acc_done_i is ignored outside WAIT.
- FIFO: circular buffer with wrapping read/write pointers and an occupancy counter.
  - Push and pop in the same cycle leave count_o unchanged.
  - Pop when empty is ignored.
  - y_o is the combinational read of the head entry; its value while empty is don't-care.
- err_o is cleared only by reset. Operation continues normally after a timeout.
- Reset mid-operation: immediate return to IDLE, FIFO flushed, start pulse suppressed. A done arriving after reset is ignored.

## Timing
- Cycle 0: operand accepted at the edge.
- Cycle 1: LAUNCH, acc_start_o high.
- Cycle 2 onward: WAIT.
- If the done edge is seen in cycle N, the FIFO write happens at the end of N.
  - y_valid_o is high in N+1 if the FIFO was empty.
  - state is IDLE in N+1, and x_ready_o is high in N+1 if space remains.
- Throughput: one operation per (accelerator latency + 3) cycles at most.
- Timeout: if start is in cycle 1 and no edge arrives, err_o rises in cycle 2+TIMEOUT and IDLE is reached in that same cycle.
- busy_o covers cycles 1 through N inclusive.

## Test plan
- Single op, accelerator model result=x+1 after 5 cycles, x=16'h1234:
  - exactly one acc_start_o pulse in cycle 1
  - y_o=16'h1235 with y_valid_o in cycle 8
  - count_o=1
- Back-pressure, DEPTH=4, y_ready_i=0, 6 operands offered:
  - 4 accepted
  - x_ready_o held 0 after the 4th result
  - no start pulse for operand 5
  - draining one entry re-opens x_ready_o the next cycle
- Level done: model holds done high until the next start; 3 back-to-back ops (x=1,2,3):
  - each result captured exactly once
  - FIFO order is 2,3,4
- Timeout, TIMEOUT=8, model never asserts done:
  - err_o=1 in cycle 10
  - FIFO unchanged, state IDLE
  - the next op with a working model completes normally with err_o still 1
- Simultaneous push/pop with count_o=2:
  - count_o stays 2
  - pointer wrap after 2*DEPTH ops preserves order
- rst_i asserted in WAIT with 2 entries queued:
  - all outputs 0 immediately (asynchronous)
  - a late done edge after release causes no FIFO write
  - count_o=0
